// File: rtl/ob_table_cnt_cpa.sv
// Serial carry-propagate resolver: folds one carry-save pair into a binary count,
// CHUNK bits per cycle, and holds the result on a valid/ready output.
module ob_table_cnt_cpa #(
    parameter int W     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_s,
    input  logic [W-1:0] in_c,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_sum,
    output logic         out_ovf
);

    localparam int NSLICE = W / CHUNK;
    localparam int CW     = $clog2(NSLICE) + 1;

    generate
        if (CHUNK < 1 || CHUNK > W || (W % CHUNK) != 0) begin : g_bad_cfg
            $error("ob_table_cnt_cpa: CHUNK must divide W and lie in 1..W");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_s;
    logic [W-1:0]    r_c;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_ovf;
    logic [CW-1:0]   r_cnt;
    logic            w_accept;
    logic            w_last;
    logic [CHUNK:0]  w_add;

    assign w_accept = in_vld & in_rdy;
    assign w_last   = (r_cnt == CW'(NSLICE - 1));
    assign w_add    = {1'b0, r_s[CHUNK-1:0]} + {1'b0, r_c[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_carry};

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        w_state_nxt = r_state;
        in_rdy      = 1'b0;
        out_vld     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (w_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_vld = 1'b1;
                // Retiring and accepting share the edge, so readiness follows the consumer.
                in_rdy  = out_rdy;
                if (out_rdy) w_state_nxt = in_vld ? ST_BUSY : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_s     <= '0;
            r_c     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_s     <= in_s;
            r_c     <= in_c;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_BUSY) begin
            r_sum[int'(r_cnt)*CHUNK +: CHUNK] <= w_add[CHUNK-1:0];
            r_carry <= w_add[CHUNK];
            r_s     <= r_s >> CHUNK;
            r_c     <= r_c >> CHUNK;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) r_ovf <= w_add[CHUNK];
        end
    end

    assign out_sum = r_sum;
    assign out_ovf = r_ovf;

endmodule

// File: tb/tb_ob_table_cnt_cpa.sv
// Bench for ob_table_cnt_cpa: directed vectors on a CHUNK=8 instance plus randomized
// traffic on CHUNK 1/4/8/32 instances checked against plain 33-bit addition.
module tb_ob_table_cnt_cpa;

    localparam int W      = 32;
    localparam int NRAND  = 600;

    logic        clk;
    logic        arst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] in_s;
    logic [31:0] in_c;
    logic        out_vld;
    logic        out_rdy;
    logic [31:0] out_sum;
    logic        out_ovf;

    int checks;
    int errors;
    bit rand_go;
    int rand_done;

    ob_table_cnt_cpa #(.W(W), .CHUNK(8)) u_dut (
        .clk(clk), .arst_n(arst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_s(in_s), .in_c(in_c), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one pair from IDLE, wait for the result, optionally retire it.
    task automatic run_add(input logic [31:0] s, input logic [31:0] c, input bit retire,
                           output logic [31:0] sum, output logic ovf, output int lat);
        @(negedge clk);
        in_s = s; in_c = c; in_vld = 1'b1; out_rdy = 1'b0;
        @(posedge clk); #1;
        in_vld = 1'b0; in_s = $urandom; in_c = $urandom;
        lat = 0;
        while (!out_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        sum = out_sum;
        ovf = out_ovf;
        if (retire) begin
            @(negedge clk); out_rdy = 1'b1;
            @(posedge clk); #1; out_rdy = 1'b0;
        end
    endtask

    typedef struct {
        logic [31:0] s;
        logic [31:0] c;
        logic [31:0] sum;
        logic        ovf;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] sum;
        logic        ovf;
        int          lat;

        checks = 0; errors = 0; rand_go = 1'b0; rand_done = 0;
        in_vld = 1'b0; in_s = '0; in_c = '0; out_rdy = 1'b0;
        arst_n = 1'b0;

        tbl[0] = '{32'h0000_0005, 32'h0000_000A, 32'h0000_000F, 1'b0};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        tbl[2] = '{32'h00FF_FFFF, 32'h0000_0001, 32'h0100_0000, 1'b0};
        tbl[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        tbl[5] = '{32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        tbl[7] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 1'b0};

        // Reset state and idle behaviour
        #12;
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ovf", out_ovf, 0);
        @(negedge clk); arst_n = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_out_vld", out_vld, 0);
        end
        out_rdy = 1'b0;

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            run_add(tbl[i].s, tbl[i].c, 1'b1, sum, ovf, lat);
            check($sformatf("tbl%0d_sum", i), sum, tbl[i].sum);
            check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
            check($sformatf("tbl%0d_lat", i), lat, 4);
            check($sformatf("tbl%0d_retired", i), out_vld, 0);
        end

        // Backpressure with a new pair waiting, then back-to-back accept
        run_add(32'h0000_0100, 32'h0000_0200, 1'b0, sum, ovf, lat);
        check("bp_first_sum", sum, 32'h0000_0300);
        @(negedge clk);
        in_vld = 1'b1; in_s = 32'hAAAA_0000; in_c = 32'h0000_5555; out_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_vld", out_vld, 1);
            check("bp_out_sum", out_sum, 32'h0000_0300);
            check("bp_in_rdy", in_rdy, 0);
        end
        @(negedge clk); out_rdy = 1'b1;
        #1 check("bp_in_rdy_release", in_rdy, 1);
        @(posedge clk); #1;
        in_vld = 1'b0; out_rdy = 1'b0; in_s = $urandom; in_c = $urandom;
        check("bp_b2b_busy_vld", out_vld, 0);
        check("bp_b2b_busy_rdy", in_rdy, 0);
        lat = 0;
        while (!out_vld && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_b2b_lat", lat, 4);
        check("bp_b2b_sum", out_sum, 32'hAAAA_5555);
        check("bp_b2b_ovf", out_ovf, 0);
        @(negedge clk); out_rdy = 1'b1;
        @(posedge clk); #1; out_rdy = 1'b0;

        // Reset in the middle of an add
        @(negedge clk);
        in_s = 32'h1234_5678; in_c = 32'h1111_1111; in_vld = 1'b1;
        @(posedge clk); #1; in_vld = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        arst_n = 1'b0;
        #1;
        check("mid_rst_in_rdy", in_rdy, 1);
        check("mid_rst_out_vld", out_vld, 0);
        check("mid_rst_out_sum", out_sum, 0);
        check("mid_rst_out_ovf", out_ovf, 0);
        @(negedge clk); arst_n = 1'b1;
        run_add(32'd3, 32'd4, 1'b1, sum, ovf, lat);
        check("post_rst_sum", sum, 32'd7);
        check("post_rst_ovf", ovf, 0);
        check("post_rst_lat", lat, 4);

        // Randomized traffic on all CHUNK variants
        rand_go = 1'b1;
        wait (rand_done == 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_rand
        localparam int CH = (gi == 0) ? 1 : (gi == 1) ? 4 : (gi == 2) ? 8 : 32;
        localparam int NS = W / CH;

        logic        r_in_vld;
        logic        w_in_rdy;
        logic [31:0] r_in_s;
        logic [31:0] r_in_c;
        logic        w_out_vld;
        logic        r_out_rdy;
        logic [31:0] w_out_sum;
        logic        w_out_ovf;
        logic [32:0] exp_q[$];

        ob_table_cnt_cpa #(.W(W), .CHUNK(CH)) u_rdut (
            .clk(clk), .arst_n(arst_n), .in_vld(r_in_vld), .in_rdy(w_in_rdy),
            .in_s(r_in_s), .in_c(r_in_c), .out_vld(w_out_vld), .out_rdy(r_out_rdy),
            .out_sum(w_out_sum), .out_ovf(w_out_ovf)
        );

        initial begin
            logic [31:0] s, c;
            logic [32:0] exp;
            bit pending, acc, ret, wait_vld;
            int sent, retired, cyc, lat;

            r_in_vld = 1'b0; r_in_s = '0; r_in_c = '0; r_out_rdy = 1'b0;
            pending = 0; wait_vld = 0; sent = 0; retired = 0; cyc = 0; lat = 0;
            s = '0; c = '0;
            wait (rand_go);
            while (retired < NRAND && cyc < 60000) begin
                @(negedge clk);
                cyc++;
                r_out_rdy = ($urandom_range(0, 1) == 1);
                if (!pending && sent < NRAND && $urandom_range(0, 3) != 0) begin
                    s = $urandom;
                    c = $urandom;
                    case ($urandom_range(0, 3))
                        0: s = 32'hFFFF_FFFF;
                        1: c = ~s;
                        2: c = -s;
                        default: ;
                    endcase
                    r_in_s = s; r_in_c = c; r_in_vld = 1'b1;
                    pending = 1;
                end
                #1;
                acc = r_in_vld & w_in_rdy;
                ret = w_out_vld & r_out_rdy;
                if (wait_vld && w_out_vld) begin
                    check($sformatf("rand_c%0d_lat", CH), lat, NS);
                    wait_vld = 0;
                end
                if (ret) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("rand_c%0d_dup", CH), 1, 0);
                    end else begin
                        exp = exp_q.pop_front();
                        check($sformatf("rand_c%0d_sum", CH), w_out_sum, exp[31:0]);
                        check($sformatf("rand_c%0d_ovf", CH), w_out_ovf, exp[32]);
                    end
                    retired++;
                end
                @(posedge clk);
                if (acc) begin
                    exp_q.push_back({1'b0, s} + {1'b0, c});
                    pending = 0; sent++; wait_vld = 1; lat = 0;
                end else if (wait_vld) begin
                    lat++;
                end
                #1;
                if (acc) begin
                    r_in_vld = 1'b0; r_in_s = $urandom; r_in_c = $urandom;
                end
            end
            r_in_vld = 1'b0; r_out_rdy = 1'b0;
            check($sformatf("rand_c%0d_retired", CH), retired, NRAND);
            check($sformatf("rand_c%0d_leftover", CH), exp_q.size(), 0);
            rand_done++;
        end
    end

endmodule
